// File: rtl/float_adder_arbiter.sv
// Two-port round-robin front end sharing one float_adder.
// Operands are latched, summed in one EXEC cycle, then held on rsp_*.
module float_adder #(
  parameter int INTEGER_WIDTH = 8,
  parameter int DECIMAL_WIDTH = 23
) (
  input  logic signed [INTEGER_WIDTH-1:0] a_integer,
  input  logic signed [DECIMAL_WIDTH-1:0] a_decimal,
  input  logic signed [INTEGER_WIDTH-1:0] b_integer,
  input  logic signed [DECIMAL_WIDTH-1:0] b_decimal,
  output logic signed [INTEGER_WIDTH-1:0] result_integer,
  output logic signed [DECIMAL_WIDTH-1:0] result_decimal
);

  assign result_integer = a_integer + b_integer;
  assign result_decimal = a_decimal + b_decimal;

endmodule

module float_adder_arbiter #(
  parameter int INTEGER_WIDTH = 8,
  parameter int DECIMAL_WIDTH = 23,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [INTEGER_WIDTH-1:0] req0_a_integer,
  input  logic [DECIMAL_WIDTH-1:0] req0_a_decimal,
  input  logic [INTEGER_WIDTH-1:0] req0_b_integer,
  input  logic [DECIMAL_WIDTH-1:0] req0_b_decimal,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [INTEGER_WIDTH-1:0] req1_a_integer,
  input  logic [DECIMAL_WIDTH-1:0] req1_a_decimal,
  input  logic [INTEGER_WIDTH-1:0] req1_b_integer,
  input  logic [DECIMAL_WIDTH-1:0] req1_b_decimal,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [INTEGER_WIDTH-1:0] rsp_integer,
  output logic [DECIMAL_WIDTH-1:0] rsp_decimal,
  output logic                     busy,
  output logic [COUNT_WIDTH-1:0]   op_count
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e                   state_q, state_d;
  logic                     last_grant_q, last_grant_d;
  logic [INTEGER_WIDTH-1:0] a_int_q, a_int_d;
  logic [DECIMAL_WIDTH-1:0] a_dec_q, a_dec_d;
  logic [INTEGER_WIDTH-1:0] b_int_q, b_int_d;
  logic [DECIMAL_WIDTH-1:0] b_dec_q, b_dec_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     rsp_id_q, rsp_id_d;
  logic [INTEGER_WIDTH-1:0] rsp_int_q, rsp_int_d;
  logic [DECIMAL_WIDTH-1:0] rsp_dec_q, rsp_dec_d;
  logic [COUNT_WIDTH-1:0]   op_count_q, op_count_d;

  logic                     gnt0, gnt1;
  logic                     acc0, acc1;
  logic [INTEGER_WIDTH-1:0] sum_int;
  logic [DECIMAL_WIDTH-1:0] sum_dec;

  float_adder #(
    .INTEGER_WIDTH(INTEGER_WIDTH),
    .DECIMAL_WIDTH(DECIMAL_WIDTH)
  ) u_adder (
    .a_integer      (a_int_q),
    .a_decimal      (a_dec_q),
    .b_integer      (b_int_q),
    .b_decimal      (b_dec_q),
    .result_integer (sum_int),
    .result_decimal (sum_dec)
  );

  // Under contention the requester that was not served last wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE) begin
      unique case (1'b1)
        (req0_valid && !req1_valid): gnt0 = 1'b1;
        (req1_valid && !req0_valid): gnt1 = 1'b1;
        (req0_valid && req1_valid): begin
          gnt0 = last_grant_q;
          gnt1 = !last_grant_q;
        end
        default: ;
      endcase
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign acc0       = req0_valid && gnt0;
  assign acc1       = req1_valid && gnt1;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_int_d      = a_int_q;
    a_dec_d      = a_dec_q;
    b_int_d      = b_int_q;
    b_dec_d      = b_dec_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_int_d    = rsp_int_q;
    rsp_dec_d    = rsp_dec_q;
    op_count_d   = op_count_q;
    case (state_q)
      IDLE: begin
        if (acc0 || acc1) begin
          a_int_d      = acc1 ? req1_a_integer : req0_a_integer;
          a_dec_d      = acc1 ? req1_a_decimal : req0_a_decimal;
          b_int_d      = acc1 ? req1_b_integer : req0_b_integer;
          b_dec_d      = acc1 ? req1_b_decimal : req0_b_decimal;
          rsp_id_d     = acc1;
          last_grant_d = acc1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_int_d   = sum_int;
        rsp_dec_d   = sum_dec;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + COUNT_WIDTH'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_int_q      <= '0;
      a_dec_q      <= '0;
      b_int_q      <= '0;
      b_dec_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_int_q    <= '0;
      rsp_dec_q    <= '0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_int_q      <= a_int_d;
      a_dec_q      <= a_dec_d;
      b_int_q      <= b_int_d;
      b_dec_q      <= b_dec_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_int_q    <= rsp_int_d;
      rsp_dec_q    <= rsp_dec_d;
      op_count_q   <= op_count_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_integer = rsp_int_q;
  assign rsp_decimal = rsp_dec_q;
  assign busy        = (state_q != IDLE);
  assign op_count    = op_count_q;

endmodule
